// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// The slave modport is the station itself; master is the dispatcher/ALU side.
interface alu_rs_if #(
    parameter int TAG_W = 4
);
    logic              dispatch_valid_i;
    logic              dispatch_ready_o;
    logic [31:0]       dispatch_pc_i;
    logic [31:0]       dispatch_inst_i;
    logic [TAG_W-1:0]  dispatch_dst_tag_i;
    logic              dispatch_rs1_ready_i;
    logic [TAG_W-1:0]  dispatch_rs1_tag_i;
    logic [31:0]       dispatch_rs1_value_i;
    logic              dispatch_rs2_ready_i;
    logic [TAG_W-1:0]  dispatch_rs2_tag_i;
    logic [31:0]       dispatch_rs2_value_i;

    logic              cdb_valid_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [31:0]       cdb_value_i;

    logic              alu_request_o;
    logic [31:0]       pc_o;
    logic [31:0]       inst_o;
    logic [31:0]       rs1_value_o;
    logic [31:0]       rs2_value_o;
    logic [TAG_W-1:0]  dst_tag_o;

    modport slave (
        input  dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_dst_tag_i,
        input  dispatch_rs1_ready_i, dispatch_rs1_tag_i, dispatch_rs1_value_i,
        input  dispatch_rs2_ready_i, dispatch_rs2_tag_i, dispatch_rs2_value_i,
        input  cdb_valid_i, cdb_tag_i, cdb_value_i,
        output dispatch_ready_o,
        output alu_request_o, pc_o, inst_o, rs1_value_o, rs2_value_o, dst_tag_o
    );

    modport master (
        output dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_dst_tag_i,
        output dispatch_rs1_ready_i, dispatch_rs1_tag_i, dispatch_rs1_value_i,
        output dispatch_rs2_ready_i, dispatch_rs2_tag_i, dispatch_rs2_value_i,
        output cdb_valid_i, cdb_tag_i, cdb_value_i,
        input  dispatch_ready_o,
        input  alu_request_o, pc_o, inst_o, rs1_value_o, rs2_value_o, dst_tag_o
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue (slot 0 oldest) with CDB wakeup,
// oldest-ready selection and a registered issue port to the arithmetic unit.
module alu_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      flush_i,
    alu_rs_if.slave   bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES) + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] dst_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_value;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_value;
    } slot_t;

    slot_t            slot_q [ENTRIES];
    slot_t            slot_n [ENTRIES];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] wr_idx;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    slot_t            new_slot;

    logic             req_q;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [TAG_W-1:0] dst_q;

    // Same match rule serves both resident wakeup and the dispatch bypass.
    function automatic slot_t wake(slot_t s, logic v, logic [TAG_W-1:0] t, logic [31:0] val);
        slot_t r;
        r = s;
        if (v && !r.rs1_rdy && r.rs1_tag == t) begin
            r.rs1_rdy   = 1'b1;
            r.rs1_value = val;
        end
        if (v && !r.rs2_rdy && r.rs2_tag == t) begin
            r.rs2_rdy   = 1'b1;
            r.rs2_value = val;
        end
        return r;
    endfunction

    assign bus.dispatch_ready_o = (count_q != CNT_W'(ENTRIES));
    assign accept = bus.dispatch_valid_i && bus.dispatch_ready_o && !flush_i;

    always_comb begin
        new_slot.pc        = bus.dispatch_pc_i;
        new_slot.inst      = bus.dispatch_inst_i;
        new_slot.dst_tag   = bus.dispatch_dst_tag_i;
        new_slot.rs1_rdy   = bus.dispatch_rs1_ready_i;
        new_slot.rs1_tag   = bus.dispatch_rs1_tag_i;
        new_slot.rs1_value = bus.dispatch_rs1_value_i;
        new_slot.rs2_rdy   = bus.dispatch_rs2_ready_i;
        new_slot.rs2_tag   = bus.dispatch_rs2_tag_i;
        new_slot.rs2_value = bus.dispatch_rs2_value_i;
    end

    // Scan from the top so the lowest ready index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        slot_n  = slot_q;
        count_n = count_q;
        wr_idx  = count_q - CNT_W'(sel_valid);
        if (flush_i) begin
            count_n = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                slot_n[i].rs1_rdy = 1'b0;
                slot_n[i].rs2_rdy = 1'b0;
            end
        end else begin
            // Shifted slots are woken on the fly so a broadcast during a collapse is kept.
            for (int i = 0; i < ENTRIES; i++) begin
                if (sel_valid && IDX_W'(i) >= sel_idx)
                    slot_n[i] = wake(slot_q[(i < ENTRIES - 1) ? i + 1 : i],
                                     bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_value_i);
                else
                    slot_n[i] = wake(slot_q[i], bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_value_i);
            end
            if (accept)
                slot_n[wr_idx[IDX_W-1:0]] = wake(new_slot, bus.cdb_valid_i, bus.cdb_tag_i,
                                                 bus.cdb_value_i);
            count_n = count_q + CNT_W'(accept) - CNT_W'(sel_valid);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
            req_q   <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            dst_q   <= '0;
        end else begin
            count_q <= count_n;
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= slot_n[i];
            if (flush_i) begin
                req_q <= 1'b0;
            end else if (sel_valid) begin
                req_q  <= 1'b1;
                pc_q   <= slot_q[sel_idx].pc;
                inst_q <= slot_q[sel_idx].inst;
                rs1_q  <= slot_q[sel_idx].rs1_value;
                rs2_q  <= slot_q[sel_idx].rs2_value;
                dst_q  <= slot_q[sel_idx].dst_tag;
            end else begin
                req_q <= 1'b0;
            end
        end
    end

    assign bus.alu_request_o = req_q;
    assign bus.pc_o          = pc_q;
    assign bus.inst_o        = inst_q;
    assign bus.rs1_value_o   = rs1_q;
    assign bus.rs2_value_o   = rs2_q;
    assign bus.dst_tag_o     = dst_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_alu_rs;
    localparam int ENTRIES = 4;
    localparam int TAG_W   = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    logic flush_i = 1'b0;

    alu_rs_if #(.TAG_W(TAG_W)) bus ();

    alu_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  dst;
        bit          r1;
        logic [3:0]  t1;
        logic [31:0] v1;
        bit          r2;
        logic [3:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t        mq[$];
    bit          e_req;
    logic [31:0] e_pc, e_inst, e_rs1, e_rs2;
    logic [3:0]  e_dst;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.dispatch_valid_i     = 1'b0;
        bus.dispatch_pc_i        = '0;
        bus.dispatch_inst_i      = '0;
        bus.dispatch_dst_tag_i   = '0;
        bus.dispatch_rs1_ready_i = 1'b1;
        bus.dispatch_rs1_tag_i   = '0;
        bus.dispatch_rs1_value_i = '0;
        bus.dispatch_rs2_ready_i = 1'b1;
        bus.dispatch_rs2_tag_i   = '0;
        bus.dispatch_rs2_value_i = '0;
        bus.cdb_valid_i          = 1'b0;
        bus.cdb_tag_i            = '0;
        bus.cdb_value_i          = '0;
        flush_i                  = 1'b0;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [31:0] inst, input logic [3:0] dst,
                            input bit r1, input logic [3:0] t1, input logic [31:0] v1,
                            input bit r2, input logic [3:0] t2, input logic [31:0] v2);
        bus.dispatch_valid_i     = 1'b1;
        bus.dispatch_pc_i        = pc;
        bus.dispatch_inst_i      = inst;
        bus.dispatch_dst_tag_i   = dst;
        bus.dispatch_rs1_ready_i = r1;
        bus.dispatch_rs1_tag_i   = t1;
        bus.dispatch_rs1_value_i = v1;
        bus.dispatch_rs2_ready_i = r2;
        bus.dispatch_rs2_tag_i   = t2;
        bus.dispatch_rs2_value_i = v2;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = tag;
        bus.cdb_value_i = val;
    endtask

    task automatic model_reset();
        mq.delete();
        e_req  = 1'b0;
        e_pc   = '0;
        e_inst = '0;
        e_rs1  = '0;
        e_rs2  = '0;
        e_dst  = '0;
    endtask

    // One clock of the reference: oldest ready issues, broadcast wakes the rest,
    // an accepted dispatch joins the tail (after a bypass check).
    task automatic model_step();
        bit   acc;
        int   k;
        ent_t e;
        acc = bus.dispatch_valid_i && (mq.size() != ENTRIES) && !flush_i;
        if (flush_i) begin
            mq.delete();
            e_req = 1'b0;
            return;
        end
        k = -1;
        foreach (mq[i]) if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
        if (k >= 0) begin
            e_req  = 1'b1;
            e_pc   = mq[k].pc;
            e_inst = mq[k].inst;
            e_rs1  = mq[k].v1;
            e_rs2  = mq[k].v2;
            e_dst  = mq[k].dst;
            mq.delete(k);
        end else begin
            e_req = 1'b0;
        end
        if (bus.cdb_valid_i) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag_i) begin
                    mq[i].r1 = 1'b1;
                    mq[i].v1 = bus.cdb_value_i;
                end
                if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag_i) begin
                    mq[i].r2 = 1'b1;
                    mq[i].v2 = bus.cdb_value_i;
                end
            end
        end
        if (acc) begin
            e.pc   = bus.dispatch_pc_i;
            e.inst = bus.dispatch_inst_i;
            e.dst  = bus.dispatch_dst_tag_i;
            e.r1   = bus.dispatch_rs1_ready_i;
            e.t1   = bus.dispatch_rs1_tag_i;
            e.v1   = bus.dispatch_rs1_value_i;
            e.r2   = bus.dispatch_rs2_ready_i;
            e.t2   = bus.dispatch_rs2_tag_i;
            e.v2   = bus.dispatch_rs2_value_i;
            if (bus.cdb_valid_i && !e.r1 && e.t1 == bus.cdb_tag_i) begin
                e.r1 = 1'b1;
                e.v1 = bus.cdb_value_i;
            end
            if (bus.cdb_valid_i && !e.r2 && e.t2 == bus.cdb_tag_i) begin
                e.r2 = 1'b1;
                e.v2 = bus.cdb_value_i;
            end
            mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        chk("req",   32'(bus.alu_request_o),    32'(e_req));
        chk("ready", 32'(bus.dispatch_ready_o), 32'(mq.size() != ENTRIES));
        chk("pc",    bus.pc_o,                  e_pc);
        chk("inst",  bus.inst_o,                e_inst);
        chk("rs1",   bus.rs1_value_o,           e_rs1);
        chk("rs2",   bus.rs2_value_o,           e_rs2);
        chk("dst",   32'(bus.dst_tag_o),        32'(e_dst));
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        check_outputs();
        idle_inputs();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_req"},   32'(bus.alu_request_o),    32'd0);
        chk({tag, "_ready"}, 32'(bus.dispatch_ready_o), 32'd1);
        chk({tag, "_pc"},    bus.pc_o,                  32'd0);
        chk({tag, "_inst"},  bus.inst_o,                32'd0);
        chk({tag, "_rs1"},   bus.rs1_value_o,           32'd0);
        chk({tag, "_rs2"},   bus.rs2_value_o,           32'd0);
        chk({tag, "_dst"},   32'(bus.dst_tag_o),        32'd0);
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 1) == 1)
                dispatch($urandom, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), $urandom,
                         $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 1) == 1)
                cdb(4'($urandom_range(0, 15)), $urandom);
            flush_i = ($urandom_range(0, 49) == 0);
            step();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #12;
        check_cleared("reset");
        @(negedge clk_i);
        reset_i = 1'b1;

        // ADDI, both operands ready: request two cycles after dispatch
        dispatch(32'h100, 32'h0050_0093, 4'd3, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd0);
        step();
        chk("addi_early", 32'(bus.alu_request_o), 32'd0);
        step();
        chk("addi_req", 32'(bus.alu_request_o), 32'd1);
        chk("addi_pc",  bus.pc_o,               32'h100);
        chk("addi_rs1", bus.rs1_value_o,        32'd7);
        chk("addi_dst", 32'(bus.dst_tag_o),     32'd3);
        step();
        chk("addi_drop", 32'(bus.alu_request_o), 32'd0);

        // ADD waiting on tag 5; wrong tag 6 must not wake it
        dispatch(32'h104, 32'h0020_81B3, 4'd4, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd1);
        step();
        step();
        cdb(4'd6, 32'h99);
        step();
        chk("wrong_tag", 32'(bus.alu_request_o), 32'd0);
        cdb(4'd5, 32'h2A);
        step();
        chk("pre_wake", 32'(bus.alu_request_o), 32'd0);
        step();
        chk("wake_req", 32'(bus.alu_request_o), 32'd1);
        chk("wake_rs1", bus.rs1_value_o,        32'h2A);
        step();

        // Fill all slots waiting on tag 9, then drain in order
        for (int i = 0; i < ENTRIES; i++) begin
            dispatch(32'h200 + 32'(4 * i), 32'h0000_0033, 4'(i), 1'b0, 4'd9, 32'd0,
                     1'b1, 4'd0, 32'(i + 10));
            step();
        end
        chk("full", 32'(bus.dispatch_ready_o), 32'd0);
        dispatch(32'h300, 32'h0000_0033, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
        step();
        cdb(4'd9, 32'h55);
        step();
        step();
        chk("drain0_pc",    bus.pc_o,                  32'h200);
        chk("drain0_ready", 32'(bus.dispatch_ready_o), 32'd1);
        for (int i = 1; i < ENTRIES; i++) begin
            step();
            chk("drain_pc", bus.pc_o, 32'h200 + 32'(4 * i));
        end
        step();
        chk("drain_end", 32'(bus.alu_request_o), 32'd0);

        // Younger ready entry overtakes; older wakes during the collapse
        dispatch(32'h400, 32'h0000_0033, 4'd1, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd5);
        step();
        dispatch(32'h404, 32'h0000_0033, 4'd2, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd9);
        step();
        cdb(4'd2, 32'h77);
        step();
        chk("ooo_b_pc", bus.pc_o, 32'h404);
        step();
        chk("ooo_a_pc",  bus.pc_o,        32'h400);
        chk("ooo_a_rs1", bus.rs1_value_o, 32'h77);
        step();

        // Dispatch bypass from a same-cycle broadcast
        dispatch(32'h500, 32'h0000_0033, 4'd6, 1'b1, 4'd0, 32'd3, 1'b0, 4'd4, 32'd0);
        cdb(4'd4, 32'hDEAD);
        step();
        step();
        chk("bypass_req", 32'(bus.alu_request_o), 32'd1);
        chk("bypass_rs2", bus.rs2_value_o,        32'hDEAD);
        step();

        // Flush with a concurrent dispatch
        for (int i = 0; i < 3; i++) begin
            dispatch(32'h600 + 32'(4 * i), 32'h0000_0033, 4'(i + 8), 1'b0, 4'd11, 32'd0,
                     1'b1, 4'd0, 32'd0);
            step();
        end
        dispatch(32'h700, 32'h0000_0033, 4'd15, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        flush_i = 1'b1;
        step();
        chk("flush_ready", 32'(bus.dispatch_ready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cdb(4'd11, 32'h11);
            step();
            chk("flush_noreq", 32'(bus.alu_request_o), 32'd0);
        end

        random_cycles(1500);

        // Asynchronous reset mid-stream, away from the clock edge
        #2;
        reset_i = 1'b0;
        #1;
        check_cleared("midrst");
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        random_cycles(300);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
